// File: rtl/gerenciador_de_posicionamento_pkg.sv
// Shared constants, state encoding and ship-size table for the ship placement block.
package gerenciador_de_posicionamento_pkg;

    localparam int NUM_COLUNAS  = 5;
    localparam int NUM_LINHAS   = 7;
    localparam int NUM_NAVIOS   = 3;
    localparam int MAX_TAMANHO  = 3;

    typedef enum logic [1:0] {
        INATIVO      = 2'd0,
        POSICIONANDO = 2'd1,
        PRONTO       = 2'd2
    } estado_t;

    // Ships shrink as placement progresses; index 3 (done) has no footprint.
    function automatic logic [1:0] tamanho_navio(input logic [1:0] indice);
        case (indice)
            2'd0:    return 2'd3;
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/gerenciador_de_posicionamento_if.sv
// Player-facing bundle of the placement block: coordinates, confirm button, maps and status LEDs.
interface gerenciador_de_posicionamento_if;
    import gerenciador_de_posicionamento_pkg::*;

    logic                  enable;
    logic [2:0]            coordColuna;
    logic [2:0]            coordLinha;
    logic                  orientacao;
    logic                  confirmar;
    logic [NUM_LINHAS-1:0] mapa0;
    logic [NUM_LINHAS-1:0] mapa1;
    logic [NUM_LINHAS-1:0] mapa2;
    logic [NUM_LINHAS-1:0] mapa3;
    logic [NUM_LINHAS-1:0] mapa4;
    logic [1:0]            navio_atual;
    logic                  pronto;
    logic                  LED_R;
    logic                  LED_G;
    logic                  LED_B;

    modport master (
        output enable, coordColuna, coordLinha, orientacao, confirmar,
        input  mapa0, mapa1, mapa2, mapa3, mapa4, navio_atual, pronto, LED_R, LED_G, LED_B
    );

    modport slave (
        input  enable, coordColuna, coordLinha, orientacao, confirmar,
        output mapa0, mapa1, mapa2, mapa3, mapa4, navio_atual, pronto, LED_R, LED_G, LED_B
    );

endinterface

// File: rtl/gerenciador_de_posicionamento_gerador_de_navio.sv
// Combinational ship footprint builder: anchor + orientation + size -> 5x7 cell mask and bounds flag.
module gerador_de_navio
    import gerenciador_de_posicionamento_pkg::*;
(
    input  logic [2:0]                             coluna_i,
    input  logic [2:0]                             linha_i,
    input  logic                                   orientacao_i,
    input  logic [1:0]                             tamanho_i,
    output logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] pegada_o,
    output logic                                   fora_do_mapa_o
);

    logic [3:0] colunaCelula;
    logic [3:0] linhaCelula;

    // One extra bit on the cell coordinates so cells past the edge are caught, not wrapped.
    always_comb begin
        pegada_o       = '0;
        fora_do_mapa_o = 1'b0;
        colunaCelula   = 4'd0;
        linhaCelula    = 4'd0;
        for (int k = 0; k < MAX_TAMANHO; k++) begin
            colunaCelula = {1'b0, coluna_i} + (orientacao_i ? 4'd0 : 4'(k));
            linhaCelula  = {1'b0, linha_i}  + (orientacao_i ? 4'(k) : 4'd0);
            if (k < int'(tamanho_i)) begin
                if (colunaCelula >= 4'(NUM_COLUNAS) || linhaCelula >= 4'(NUM_LINHAS)) begin
                    fora_do_mapa_o = 1'b1;
                end else begin
                    pegada_o[colunaCelula[2:0]][linhaCelula[2:0]] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gerenciador_de_posicionamento.sv
// Ship placement manager: confirm edge detection, overlap check, placement FSM and map registers.
module gerenciador_de_posicionamento #(
    parameter int NUM_COLUNAS = gerenciador_de_posicionamento_pkg::NUM_COLUNAS,
    parameter int NUM_LINHAS  = gerenciador_de_posicionamento_pkg::NUM_LINHAS,
    parameter int NUM_NAVIOS  = gerenciador_de_posicionamento_pkg::NUM_NAVIOS
) (
    input  logic                          clock,
    input  logic                          reset,
    gerenciador_de_posicionamento_if.slave bus
);
    import gerenciador_de_posicionamento_pkg::*;

    estado_t                               estado_q, estado_d;
    logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] mapa_q, mapa_d;
    logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] pegada;
    logic [1:0]                             navio_q, navio_d;
    logic                                   ledR_q, ledR_d;
    logic                                   ledG_q, ledG_d;
    logic                                   ledB_q, ledB_d;
    logic                                   confirmar_q;
    logic                                   evento;
    logic                                   foraDoMapa;
    logic                                   sobreposicao;
    logic [1:0]                             tamanho;

    assign tamanho      = tamanho_navio(navio_q);
    assign evento       = bus.confirmar & ~confirmar_q;
    assign sobreposicao = |(pegada & mapa_q);

    gerador_de_navio u_gerador (
        .coluna_i       (bus.coordColuna),
        .linha_i        (bus.coordLinha),
        .orientacao_i   (bus.orientacao),
        .tamanho_i      (tamanho),
        .pegada_o       (pegada),
        .fora_do_mapa_o (foraDoMapa)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INATIVO;
            mapa_q      <= '0;
            navio_q     <= 2'd0;
            ledR_q      <= 1'b0;
            ledG_q      <= 1'b0;
            ledB_q      <= 1'b0;
            confirmar_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            mapa_q      <= mapa_d;
            navio_q     <= navio_d;
            ledR_q      <= ledR_d;
            ledG_q      <= ledG_d;
            ledB_q      <= ledB_d;
            confirmar_q <= bus.confirmar;
        end
    end

    // Dropping enable wipes the whole placement from any state, before any confirm is considered.
    always_comb begin
        estado_d = estado_q;
        mapa_d   = mapa_q;
        navio_d  = navio_q;
        ledR_d   = ledR_q;
        ledG_d   = ledG_q;
        ledB_d   = ledB_q;
        if (!bus.enable) begin
            estado_d = INATIVO;
            mapa_d   = '0;
            navio_d  = 2'd0;
            ledR_d   = 1'b0;
            ledG_d   = 1'b0;
            ledB_d   = 1'b0;
        end else begin
            case (estado_q)
                INATIVO: estado_d = POSICIONANDO;
                POSICIONANDO: begin
                    if (evento) begin
                        if (!foraDoMapa && !sobreposicao) begin
                            mapa_d  = mapa_q | pegada;
                            navio_d = navio_q + 2'd1;
                            ledR_d  = 1'b0;
                            ledG_d  = 1'b1;
                            if (navio_q == 2'(NUM_NAVIOS - 1)) begin
                                estado_d = PRONTO;
                                ledG_d   = 1'b0;
                                ledB_d   = 1'b1;
                            end
                        end else begin
                            ledR_d = 1'b1;
                            ledG_d = 1'b0;
                        end
                    end
                end
                PRONTO:  estado_d = PRONTO;
                default: estado_d = INATIVO;
            endcase
        end
    end

    assign bus.mapa0       = mapa_q[0];
    assign bus.mapa1       = mapa_q[1];
    assign bus.mapa2       = mapa_q[2];
    assign bus.mapa3       = mapa_q[3];
    assign bus.mapa4       = mapa_q[4];
    assign bus.navio_atual = navio_q;
    assign bus.pronto      = (estado_q == PRONTO);
    assign bus.LED_R       = ledR_q;
    assign bus.LED_G       = ledG_q;
    assign bus.LED_B       = ledB_q;

endmodule
